// File: rtl/wb_slave_regfile_if.sv
// Wishbone B4 classic bus bundle between a master and the register-file slave.
interface wb_slave_regfile_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] adr_i;
  logic [DATA_WIDTH-1:0] dat_i;
  logic [DATA_WIDTH-1:0] dat_o;
  logic [7:0]            sel_i;
  logic                  we_i;
  logic                  stb_i;
  logic                  cyc_i;
  logic                  ack_o;
  logic                  err_o;

  modport slave (
    input  adr_i, dat_i, sel_i, we_i, stb_i, cyc_i,
    output dat_o, ack_o, err_o
  );

  modport master (
    output adr_i, dat_i, sel_i, we_i, stb_i, cyc_i,
    input  dat_o, ack_o, err_o
  );
endinterface

// File: rtl/wb_slave_regfile.sv
// Wishbone B4 classic slave register file with granule selects, read-only
// status registers fed from hw_i, per-register write strobes and error
// termination for out-of-range or read-only writes.
module wb_slave_regfile #(
  parameter int                    ADDR_WIDTH  = 16,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    GRANULE     = 8,
  parameter int                    NUM_REGS    = 4,
  parameter logic [NUM_REGS-1:0]   RO_MASK     = '0,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  wb_slave_regfile_if.slave              wb,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_i,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
  output logic [NUM_REGS-1:0]            wr_stb_o
);

  localparam int NG    = DATA_WIDTH / GRANULE;
  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  // One extra bit so NUM_REGS itself is always representable in the compare.
  localparam logic [ADDR_WIDTH:0] LP_NUM = (ADDR_WIDTH+1)'(NUM_REGS);

  typedef enum logic [1:0] {S_IDLE, S_PROCESS, S_WAIT} state_t;

  state_t                r_state;
  logic                  r_ack;
  logic                  r_err;
  logic [DATA_WIDTH-1:0] r_dat;
  logic [NUM_REGS-1:0]   r_wr_stb;
  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

  logic                  w_oob;
  logic [IDX_W-1:0]      w_idx;
  logic                  w_invalid;
  logic                  w_write;
  logic [DATA_WIDTH-1:0] w_src;
  logic [DATA_WIDTH-1:0] w_lane_mask;
  logic                  w_unused_sel;

  // Full-width address compare: any high address bit set is out of range.
  assign w_oob     = ({1'b0, wb.adr_i} >= LP_NUM);
  assign w_idx     = wb.adr_i[IDX_W-1:0];
  assign w_invalid = w_oob | (wb.we_i & RO_MASK[w_idx]);
  assign w_write   = (r_state == S_PROCESS) & wb.cyc_i & wb.we_i & ~w_invalid;
  assign w_src     = RO_MASK[w_idx] ? hw_i[w_idx*DATA_WIDTH +: DATA_WIDTH] : r_regs[w_idx];

  // Select bits beyond the number of granules are deliberately ignored.
  assign w_unused_sel = ^wb.sel_i;

  // Expand granule selects into a bit mask over the data word.
  always_comb begin
    w_lane_mask = '0;
    for (int g = 0; g < NG; g++) begin
      w_lane_mask[g*GRANULE +: GRANULE] = {GRANULE{wb.sel_i[g]}};
    end
  end

  // Bus FSM: sample the access in PROCESS, hold termination until stb drops.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state  <= S_IDLE;
      r_ack    <= 1'b0;
      r_err    <= 1'b0;
      r_dat    <= '0;
      r_wr_stb <= '0;
    end else begin
      r_wr_stb <= '0;
      case (r_state)
        S_IDLE: begin
          if (wb.cyc_i && wb.stb_i) r_state <= S_PROCESS;
        end
        S_PROCESS: begin
          if (!wb.cyc_i) begin
            r_state <= S_IDLE;
          end else begin
            r_state <= S_WAIT;
            if (w_invalid) begin
              r_err <= 1'b1;
            end else begin
              r_ack <= 1'b1;
              if (wb.we_i) r_wr_stb <= NUM_REGS'(1) << w_idx;
              else         r_dat    <= w_src & w_lane_mask;
            end
          end
        end
        S_WAIT: begin
          if (!wb.stb_i) begin
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Register storage: granule-masked update on a valid write in PROCESS.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      for (int n = 0; n < NUM_REGS; n++) r_regs[n] <= RESET_VALUE;
    end else if (w_write) begin
      r_regs[w_idx] <= (r_regs[w_idx] & ~w_lane_mask) | (wb.dat_i & w_lane_mask);
    end
  end

  // Read-only slices of regs_o are forced to zero.
  for (genvar n = 0; n < NUM_REGS; n++) begin : g_regs_o
    assign regs_o[n*DATA_WIDTH +: DATA_WIDTH] = RO_MASK[n] ? '0 : r_regs[n];
  end

  assign wr_stb_o  = r_wr_stb;
  assign wb.dat_o  = r_dat;
  assign wb.ack_o  = wb.stb_i & r_ack;
  assign wb.err_o  = wb.stb_i & r_err;

endmodule

// File: tb/tb_wb_slave_regfile.sv
// Self-checking bench for wb_slave_regfile: directed steps plus randomized
// accesses compared against a behavioural register-file model.
module tb_wb_slave_regfile;

  localparam int              AW = 16;
  localparam int              DW = 32;
  localparam int              NR = 4;
  localparam logic [NR-1:0]   RO = 4'b1000;
  localparam logic [DW-1:0]   RV = 32'hA5A5A5A5;

  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  wb_slave_regfile_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  logic [NR*DW-1:0] hw_i;
  logic [NR*DW-1:0] regs_o;
  logic [NR-1:0]    wr_stb_o;

  wb_slave_regfile #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .GRANULE(8), .NUM_REGS(NR),
    .RO_MASK(RO), .RESET_VALUE(RV)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .wb(bus),
    .hw_i(hw_i), .regs_o(regs_o), .wr_stb_o(wr_stb_o)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Behavioural model: register contents and last returned read data.
  logic [DW-1:0] m_reg [NR];
  logic [DW-1:0] m_dat;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] exp_regs();
    logic [127:0] v = '0;
    for (int n = 0; n < NR; n++) if (!RO[n]) v[n*DW +: DW] = m_reg[n];
    return v;
  endfunction

  function automatic logic [DW-1:0] lanes(input logic [7:0] sel);
    logic [DW-1:0] m = '0;
    for (int g = 0; g < DW/8; g++) if (sel[g]) m = m | (32'hFF << (8*g));
    return m;
  endfunction

  function automatic void model_reset();
    for (int n = 0; n < NR; n++) m_reg[n] = RV;
    m_dat = '0;
  endfunction

  task automatic bus_idle();
    bus.cyc_i = 1'b0; bus.stb_i = 1'b0; bus.we_i = 1'b0;
    bus.adr_i = '0;   bus.dat_i = '0;   bus.sel_i = '0;
  endtask

  // One complete access; predicts and checks every observable along the way.
  task automatic access(input logic [AW-1:0] adr, input logic we, input logic [7:0] sel,
                        input logic [DW-1:0] d, input bit new_hw);
    bit            inval;
    logic [NR-1:0] e_stb;
    logic [DW-1:0] src;
    inval = (adr >= NR) || (we && RO[adr[1:0]]);
    e_stb = '0;
    @(negedge clk_i);
    bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.adr_i = adr;
    bus.we_i = we;    bus.sel_i = sel;  bus.dat_i = d;
    if (!inval) begin
      if (we) begin
        m_reg[adr] = (m_reg[adr] & ~lanes(sel)) | (d & lanes(sel));
        e_stb = NR'(1) << adr;
      end else begin
        src   = RO[adr[1:0]] ? hw_i[adr*DW +: DW] : m_reg[adr];
        m_dat = src & lanes(sel);
      end
    end
    @(negedge clk_i);
    chk("early_ack", bus.ack_o, 1'b0);
    chk("early_err", bus.err_o, 1'b0);
    @(negedge clk_i);
    chk("ack", bus.ack_o, !inval);
    chk("err", bus.err_o, inval);
    chk("wr_stb", wr_stb_o, e_stb);
    chk("regs", regs_o, exp_regs());
    chk("dat", bus.dat_o, m_dat);
    if (new_hw) hw_i = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk_i);
    chk("wr_stb_clr", wr_stb_o, 4'b0);
    chk("dat_hold", bus.dat_o, m_dat);
    chk("term_hold", {bus.ack_o, bus.err_o}, {!inval, inval});
    bus.stb_i = 1'b0; bus.cyc_i = 1'b0;
    #1;
    chk("ack_drop", bus.ack_o, 1'b0);
    chk("err_drop", bus.err_o, 1'b0);
  endtask

  initial begin
    logic [AW-1:0] adr;
    bus_idle();
    hw_i  = '0;
    rst_i = 1'b0;
    model_reset();

    // Reset for two cycles.
    @(negedge clk_i);
    @(negedge clk_i);
    chk("rst_regs", regs_o, {32'h0, RV, RV, RV});
    chk("rst_ack", bus.ack_o, 1'b0);
    chk("rst_err", bus.err_o, 1'b0);
    chk("rst_dat", bus.dat_o, 32'h0);
    chk("rst_stb", wr_stb_o, 4'b0);
    rst_i = 1'b1;

    // Full write then read back.
    access(16'd2, 1'b1, 8'h0F, 32'hDEADBEEF, 0);
    chk("full_wr_reg2", regs_o[2*DW +: DW], 32'hDEADBEEF);
    access(16'd2, 1'b0, 8'h0F, 32'h0, 0);
    chk("full_rd", bus.dat_o, 32'hDEADBEEF);

    // Partial write and partial read.
    access(16'd1, 1'b1, 8'h0F, 32'h11223344, 0);
    access(16'd1, 1'b1, 8'h05, 32'hAABBCCDD, 0);
    chk("part_wr", regs_o[1*DW +: DW], 32'h11BB33DD);
    access(16'd1, 1'b0, 8'h02, 32'h0, 0);
    chk("part_rd", bus.dat_o, 32'h00003300);

    // Read-only register returns hw_i; write is rejected.
    hw_i[3*DW +: DW] = 32'h12345678;
    access(16'd3, 1'b0, 8'h0F, 32'h0, 1);
    chk("ro_rd", bus.dat_o, 32'h12345678);
    access(16'd3, 1'b1, 8'h0F, 32'hFFFFFFFF, 0);
    chk("ro_wr_dat", bus.dat_o, 32'h12345678);

    // Out-of-range and high address bits.
    access(16'd7, 1'b0, 8'h0F, 32'h0, 0);
    chk("oob_dat", bus.dat_o, 32'h12345678);
    access(16'h8001, 1'b1, 8'h0F, 32'h0, 0);
    access(16'd0, 1'b0, 8'h0F, 32'h0, 0);
    chk("after_oob_rd", bus.dat_o, RV);

    // Abort: cyc dropped while in PROCESS, stb left high.
    @(negedge clk_i);
    bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.adr_i = 16'd1;
    bus.we_i = 1'b1;  bus.sel_i = 8'h0F; bus.dat_i = 32'hCAFEF00D;
    @(negedge clk_i);
    bus.cyc_i = 1'b0;
    @(negedge clk_i);
    chk("abort_ack", bus.ack_o, 1'b0);
    chk("abort_err", bus.err_o, 1'b0);
    chk("abort_stb", wr_stb_o, 4'b0);
    chk("abort_regs", regs_o, exp_regs());
    @(negedge clk_i);
    chk("abort_ack2", bus.ack_o, 1'b0);
    bus.stb_i = 1'b0;
    access(16'd1, 1'b0, 8'h0F, 32'h0, 0);

    // Reset during WAIT_FOR_PHASE_END with stb held high.
    @(negedge clk_i);
    bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.adr_i = 16'd0;
    bus.we_i = 1'b1;  bus.sel_i = 8'h0F; bus.dat_i = 32'h0BADF00D;
    @(negedge clk_i);
    @(negedge clk_i);
    chk("mid_ack", bus.ack_o, 1'b1);
    chk("mid_reg0", regs_o[DW-1:0], 32'h0BADF00D);
    rst_i = 1'b0;
    @(negedge clk_i);
    model_reset();
    chk("mid_rst_ack", bus.ack_o, 1'b0);
    chk("mid_rst_err", bus.err_o, 1'b0);
    chk("mid_rst_regs", regs_o, exp_regs());
    chk("mid_rst_dat", bus.dat_o, 32'h0);
    rst_i = 1'b1;
    bus_idle();
    access(16'd0, 1'b0, 8'h0F, 32'h0, 0);

    // Randomized accesses against the model.
    for (int i = 0; i < 150; i++) begin
      adr = AW'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) adr = adr | 16'h0100;
      hw_i = {$urandom, $urandom, $urandom, $urandom};
      access(adr, 1'($urandom), 8'($urandom), $urandom, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_slave_regfile.md
Name: wb_slave_regfile

Overview:
- Parametrised Wishbone B4 classic slave holding NUM_REGS registers of DATA_WIDTH bits, with per-granule byte-lane selects.
- Each register is individually configurable as read/write or read-only; read-only registers reflect a hardware status input.
- Provides a one-cycle write-strobe per register to downstream logic, and signals an error on invalid accesses.
- Sits on the peripheral Wishbone bus as the control/status block for a peripheral.

Parameters:
- ADDR_WIDTH, 16, width of adr_i; word address, so register index = adr_i.
- DATA_WIDTH, 32, register and data-bus width; legal values 8, 16, 32, 64.
- GRANULE, 8, select granularity in bits; DATA_WIDTH/GRANULE ≤ 8.
- NUM_REGS, 4, number of registers; 1..256.
- RO_MASK, 0, NUM_REGS bits; bit n=1 makes register n read-only.
- RESET_VALUE, 0, DATA_WIDTH bits; reset value of every read/write register.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; synchronous, active-low.
- adr_i  in  ADDR_WIDTH  word address.
- dat_i  in  DATA_WIDTH  write data.
- dat_o  out  DATA_WIDTH  read data.
- sel_i  in  8  lane selects; bit i selects granule i (granule 0 = LSBs); bits ≥ DATA_WIDTH/GRANULE are ignored.
- we_i  in  1  write enable.
- stb_i  in  1  strobe.
- cyc_i  in  1  cycle.
- ack_o  out  1  acknowledge.
- err_o  out  1  error termination.
- hw_i  in  NUM_REGS*DATA_WIDTH  status value for read-only register n, on slice [n*DATA_WIDTH +: DATA_WIDTH].
- regs_o  out  NUM_REGS*DATA_WIDTH  current contents of the read/write registers; read-only slices drive 0.
- wr_stb_o  out  NUM_REGS  one-cycle pulse on bit n when register n is written.

Behaviour:
- Reset (rst_i=0 at a clk_i edge):
  - state←IDLE; internal ack/err←0; dat_o←0; wr_stb_o←0.
  - All read/write registers←RESET_VALUE.
  - Reset overrides any in-progress access; no write occurs in that cycle.
- FSM states: IDLE, PROCESS, WAIT_FOR_PHASE_END.
- IDLE: on cyc_i & stb_i, go to PROCESS. Address and controls are sampled in PROCESS; the master holds them stable until termination.
- PROCESS:
  - If cyc_i=0: return to IDLE with no access and no termination.
  - Else decode: invalid = (adr_i ≥ NUM_REGS) | (we_i & RO_MASK[adr_i]).
  - Invalid access: err←1, no register change, dat_o unchanged.
  - Valid write: for each selected granule, register[adr_i] granule←dat_i granule; wr_stb_o[adr_i]←1 for exactly one cycle, even when sel_i=0; ack←1.
  - Valid read: each selected granule of dat_o←source granule; unselected dat_o granules←0. Source is hw_i slice for read-only registers, otherwise the register. ack←1.
  - Go to WAIT_FOR_PHASE_END.
- WAIT_FOR_PHASE_END: wr_stb_o←0; when stb_i=0, ack←0, err←0, go to IDLE.
- ack_o = stb_i & ack; err_o = stb_i & err. ack and err are never both 1.
- Latency: stb_i asserted before edge k → ack_o/err_o high after edge k+1; minimum 2 cycles per access, plus 1 idle cycle between back-to-back strobes.
- Write data is visible on regs_o the cycle after the PROCESS edge, concurrent with ack and wr_stb_o.
- hw_i is sampled on the PROCESS edge only; later changes do not affect the returned dat_o.
- Address width: adr_i wider than index bits is compared in full, so high address bits set causes err.

Test Plan:
- Reset: rst_i=0 for 2 cycles with DATA_WIDTH=32, RESET_VALUE=0xA5A5A5A5 → regs_o all slices 0xA5A5A5A5 (RO slices 0), ack_o=err_o=0, dat_o=0.
- Full write/read: write 0xDEADBEEF to adr 2 with sel=0xF → ack_o 2 cycles after stb; wr_stb_o=0b0100 for one cycle. Then read adr 2 → dat_o=0xDEADBEEF.
- Partial write: reg1=0x11223344, write 0xAABBCCDD with sel=0b0101 → reg1=0x11BB33DD. Then read with sel=0b0010 → dat_o=0x00003300.
- Read-only register: RO_MASK=0b1000, hw_i slice 3=0x12345678; read adr 3 → 0x12345678. Write adr 3 → err_o=1, ack_o=0, wr_stb_o=0, no change.
- Out-of-range: NUM_REGS=4, read adr 7 → err_o=1, dat_o unchanged. Then valid read adr 0 → ack_o=1, err_o=0.
- Abort and reset mid-access: drop cyc_i in PROCESS → no write, no ack, state IDLE. Assert rst_i=0 during WAIT_FOR_PHASE_END with stb_i held high → ack_o=0 next cycle, register back to RESET_VALUE.
